// File: rtl/Pipe_Buf_Reg_PKG.sv
// Shared pipeline package: data-memory responder state encoding and RISC-V
// load/store funct3 codes.
package Pipe_Buf_Reg_PKG;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Stores only know SB/SH/SW; the unsigned variants are load-only.
  function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
    if (write)
      return !(f3 inside {F3_SB, F3_SH, F3_SW});
    return !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: load extract/extend, store merge and
// misalignment / illegal-funct3 detection for one memory word.
module dmem_lane_align
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              write,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_word,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wr_word,
  output logic              wr_en,
  output logic              err
);

  localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(8'hFF);
  localparam logic [DATA_W-1:0] HALF_MASK = DATA_W'(16'hFFFF);

  logic [4:0]        sh;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] lane_mask;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic              misaligned;

  always_comb begin
    sh         = {addr_lo, 3'b000};
    shifted    = mem_word >> sh;
    rbyte      = shifted[7:0];
    rhalf      = shifted[15:0];
    misaligned = 1'b0;
    lane_mask  = '0;
    rdata      = '0;
    case (funct3)
      F3_LB: begin
        lane_mask = BYTE_MASK << sh;
        rdata     = {{(DATA_W-8){rbyte[7]}}, rbyte};
      end
      F3_LH: begin
        misaligned = addr_lo[0];
        lane_mask  = HALF_MASK << sh;
        rdata      = {{(DATA_W-16){rhalf[15]}}, rhalf};
      end
      F3_LW: begin
        misaligned = (addr_lo != 2'b00);
        lane_mask  = '1;
        rdata      = mem_word;
      end
      F3_LBU: rdata = {{(DATA_W-8){1'b0}}, rbyte};
      F3_LHU: begin
        misaligned = addr_lo[0];
        rdata      = {{(DATA_W-16){1'b0}}, rhalf};
      end
      default: ;
    endcase
    err     = misaligned | f3_illegal(write, funct3);
    wr_en   = write & ~err;
    wr_word = (mem_word & ~lane_mask) | ((wdata << sh) & lane_mask);
    if (write || err)
      rdata = '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, fixed wait-state latency,
// held response out. Word-organised little-endian storage.
module dmem_responder
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int unsigned DM_ADDRESS  = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned IDX_W    = DM_ADDRESS - 2;
  localparam int unsigned WORDS    = 2 ** IDX_W;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_t           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [2:0]            f3_q, f3_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     mem_q [WORDS];

  logic                  acc_write;
  logic [DM_ADDRESS-1:0] acc_addr;
  logic [DATA_W-1:0]     acc_wdata;
  logic [2:0]            acc_f3;
  logic [IDX_W-1:0]      acc_idx;
  logic [DATA_W-1:0]     al_rdata;
  logic [DATA_W-1:0]     al_wr_word;
  logic                  al_wr_en;
  logic                  al_err;
  logic                  enter_resp;
  logic                  mem_we;

  // With zero wait states RESP is entered on the accept edge itself, so the
  // lane logic must see the live request rather than the latched copy.
  always_comb begin
    acc_write = (state_q == IDLE) ? req_write  : write_q;
    acc_addr  = (state_q == IDLE) ? req_addr   : addr_q;
    acc_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
    acc_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
    acc_idx   = acc_addr[DM_ADDRESS-1:2];
  end

  dmem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .write    (acc_write),
    .addr_lo  (acc_addr[1:0]),
    .funct3   (acc_f3),
    .wdata    (acc_wdata),
    .mem_word (mem_q[acc_idx]),
    .rdata    (al_rdata),
    .wr_word  (al_wr_word),
    .wr_en    (al_wr_en),
    .err      (al_err)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    enter_resp  = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          f3_d        = req_funct3;
          req_ready_d = 1'b0;
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0)
          enter_resp = 1'b1;
        else
          cnt_d = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rdata_d     = '0;
          err_d       = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase

    if (enter_resp) begin
      state_d     = RESP;
      cnt_d       = '0;
      rsp_valid_d = 1'b1;
      rdata_d     = al_rdata;
      err_d       = al_err;
      mem_we      = al_wr_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < WORDS; i++)
        mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      if (mem_we)
        mem_q[acc_idx] <= al_wr_word;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance driven from a vector
// table plus corner sequences, and a WAIT_CYCLES=0 instance streamed back-to-back.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [8:0]  z_req_addr;
  logic [31:0] z_req_wdata;
  logic [2:0]  z_req_funct3;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  exp_t sb0_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_funct3(z_req_funct3),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pop_and_check(input string name);
    exp_t e;
    check({name, ".sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({name, ".rdata"}, rsp_rdata, e.rdata);
      check({name, ".err"}, 32'(rsp_err), 32'(e.err));
    end
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance with rsp_ready high.
  task automatic do_req(input string name, input logic wr, input logic [8:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    @(negedge clk);
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    req_valid  = 1'b1;
    check({name, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    sb_q.push_back('{exp_rdata, exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, ".latency"}, 32'(lat), 32'd3);
    if (rsp_valid)
      pop_and_check(name);
    else
      void'(sb_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   lat;
    int   last_acc;
    int   acc_n;
    exp_t e0;

    vecs.push_back('{1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 9'h010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 9'h011, 32'h00000080, 3'b000, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 9'h011, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0});
    vecs.push_back('{1'b0, 9'h011, 32'h0,        3'b100, 32'h00000080, 1'b0});
    vecs.push_back('{1'b0, 9'h010, 32'h0,        3'b010, 32'hDEAD80EF, 1'b0});
    vecs.push_back('{1'b0, 9'h012, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0});
    vecs.push_back('{1'b0, 9'h013, 32'h0,        3'b001, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 9'h012, 32'h11111111, 3'b010, 32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 9'h010, 32'h0,        3'b010, 32'hDEAD80EF, 1'b0});
    vecs.push_back('{1'b0, 9'h012, 32'h0,        3'b101, 32'h0000DEAD, 1'b0});
    vecs.push_back('{1'b1, 9'h010, 32'hFFFF1234, 3'b001, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 9'h010, 32'h0,        3'b010, 32'hDEAD1234, 1'b0});
    vecs.push_back('{1'b0, 9'h010, 32'h0,        3'b011, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 9'h010, 32'h0,        3'b100, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 9'h010, 32'h0,        3'b111, 32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 9'h010, 32'h0,        3'b110, 32'h00000000, 1'b1});
    vecs.push_back('{1'b0, 9'h010, 32'h0,        3'b010, 32'hDEAD1234, 1'b0});
    vecs.push_back('{1'b0, 9'h013, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0});
    vecs.push_back('{1'b1, 9'h1FC, 32'hA5A5A5A5, 3'b010, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 9'h1FE, 32'h0,        3'b001, 32'hFFFFA5A5, 1'b0});
    vecs.push_back('{1'b0, 9'h000, 32'h0,        3'b010, 32'h00000000, 1'b0});
    vecs.push_back('{1'b1, 9'h1FF, 32'h0000007F, 3'b000, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 9'h1FC, 32'h0,        3'b010, 32'h7FA5A5A5, 1'b0});

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_funct3 = '0;
    z_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rdata", rsp_rdata, 32'h0);
    check("rst.err", 32'(rsp_err), 32'd0);
    check("rst0.req_ready", 32'(z_req_ready), 32'd1);
    check("rst0.rsp_valid", 32'(z_rsp_valid), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      do_req($sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].f3, vecs[i].exp_rdata, vecs[i].exp_err);

    // Response held with rsp_ready low; a store pulse during the hold is ignored.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = 9'h010; req_funct3 = 3'b010; req_valid = 1'b1;
    @(posedge clk);
    sb_q.push_back('{32'hDEAD1234, 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("hold.latency", 32'(lat), 32'd3);
    pop_and_check("hold");
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d.rsp_valid", k), 32'(rsp_valid), 32'd1);
      check($sformatf("hold%0d.rdata", k), rsp_rdata, 32'hDEAD1234);
      check($sformatf("hold%0d.err", k), 32'(rsp_err), 32'd0);
      check($sformatf("hold%0d.req_ready", k), 32'(req_ready), 32'd0);
      if (k == 1) begin
        req_write = 1'b1; req_wdata = 32'hFFFFFFFF; req_valid = 1'b1;
      end else begin
        req_valid = 1'b0; req_write = 1'b0;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("hold.release.rsp_valid", 32'(rsp_valid), 32'd0);
    check("hold.release.req_ready", 32'(req_ready), 32'd1);
    do_req("hold.after", 1'b0, 9'h010, 32'h0, 3'b010, 32'hDEAD1234, 1'b0);

    // Reset while a store is in WAIT: the store is abandoned.
    @(negedge clk);
    req_write = 1'b1; req_addr = 9'h020; req_wdata = 32'h12345678; req_funct3 = 3'b010;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstwait.in_wait.req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstwait.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstwait.req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("rstwait.no_late_rsp", 32'(rsp_valid), 32'd0);
    do_req("rstwait.lw020", 1'b0, 9'h020, 32'h0, 3'b010, 32'h00000000, 1'b0);
    do_req("rstwait.lw010", 1'b0, 9'h010, 32'h0, 3'b010, 32'h00000000, 1'b0);

    // Zero-wait instance: SW then a stream of LWs with rsp_ready tied high.
    last_acc = -10;
    acc_n = 0;
    @(negedge clk);
    z_req_write = 1'b1; z_req_addr = 9'h004; z_req_wdata = 32'hCAFEF00D;
    z_req_funct3 = 3'b010; z_req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (z_rsp_valid) begin
        check($sformatf("w0.c%0d.latency", i), 32'(i - last_acc), 32'd1);
        check($sformatf("w0.c%0d.sb_nonempty", i), 32'(sb0_q.size() != 0), 32'd1);
        if (sb0_q.size() != 0) begin
          e0 = sb0_q.pop_front();
          check($sformatf("w0.c%0d.rdata", i), z_rsp_rdata, e0.rdata);
          check($sformatf("w0.c%0d.err", i), 32'(z_rsp_err), 32'(e0.err));
        end
      end
      if (z_req_valid && z_req_ready) begin
        if (acc_n > 0)
          check($sformatf("w0.c%0d.gap", i), 32'(i - last_acc), 32'd2);
        sb0_q.push_back('{(z_req_write ? 32'h0 : 32'hCAFEF00D), 1'b0});
        last_acc = i;
        acc_n++;
      end
      @(negedge clk);
      if (acc_n >= 1)
        z_req_write = 1'b0;
    end
    z_req_valid = 1'b0;
    check("w0.accepts", 32'(acc_n), 32'd6);
    check("w0.sb_drained", 32'(sb0_q.size()), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
